// File: rtl/masked_run_ctrl_if.sv
// masked_run_ctrl_if: run request/result handshakes plus the core-side en/rng/done/o bundle
interface masked_run_ctrl_if #(
  parameter int D = 2,
  parameter int RND_W = 1
);
  logic start_valid, start_ready;
  logic res_valid, res_ready, res_err;
  logic [D-1:0] res_shares;
  logic dut_en, dut_done;
  logic [RND_W-1:0] dut_rng;
  logic [D-1:0] dut_o;
  modport master (
    input start_valid, res_ready, dut_done, dut_o,
    output start_ready, res_valid, res_shares, res_err, dut_en, dut_rng
  );
  modport slave (
    output start_valid, res_ready, dut_done, dut_o,
    input start_ready, res_valid, res_shares, res_err, dut_en, dut_rng
  );
endinterface

// File: rtl/masked_run_ctrl.sv
// masked_run_ctrl: sequences one masked-core run (launch, fresh LFSR randomness, capture shares); MRC_TIMEOUT_EN adds a WAIT timeout
module masked_run_ctrl #(
  parameter int D = 2,
  parameter int RND_W = 1,
  parameter int LAT_MAX = 16,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input logic clk,
  input logic rst,
  masked_run_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
  state_t state;
  logic en_q, vld_q, err_q, expire;
  logic [RND_W-1:0] rng_q;
  logic [D-1:0] sh_q;
  logic [31:0] lfsr, lfsr_nx;
  if (LAT_MAX < 1 || SEED == 32'd0) begin : g_bad_cfg
    $error("masked_run_ctrl: LAT_MAX must be >= 1 and SEED nonzero");
  end
  assign lfsr_nx = (lfsr >> 1) ^ ({32{lfsr[0]}} & 32'h8020_0003);
`ifdef MRC_TIMEOUT_EN
  localparam int CW = $clog2(LAT_MAX + 1);
  logic [CW-1:0] cnt;
  assign expire = cnt == CW'(LAT_MAX - 1);
`else
  assign expire = 1'b0;
  assign err_q = 1'b0;
`endif
  assign bus.start_ready = state == IDLE && !rst;
  assign bus.res_valid = vld_q;
  assign bus.res_shares = sh_q;
  assign bus.res_err = err_q;
  assign bus.dut_en = en_q;
  assign bus.dut_rng = rng_q;
  // run FSM; rng/lfsr advance only on edges entering LAUNCH/WAIT cycles, shares copied verbatim
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      en_q <= 1'b0;
      rng_q <= '0;
      vld_q <= 1'b0;
      sh_q <= '0;
      lfsr <= SEED;
`ifdef MRC_TIMEOUT_EN
      err_q <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      en_q <= 1'b0;
      rng_q <= '0;
      case (state)
        IDLE: if (bus.start_valid) begin
          state <= LAUNCH;
          en_q <= 1'b1;
          rng_q <= lfsr[RND_W-1:0];
          lfsr <= lfsr_nx;
        end
        LAUNCH: begin
          state <= WAIT;
          rng_q <= lfsr[RND_W-1:0];
          lfsr <= lfsr_nx;
`ifdef MRC_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        WAIT: if (bus.dut_done) begin
          state <= HOLD;
          vld_q <= 1'b1;
          sh_q <= bus.dut_o;
`ifdef MRC_TIMEOUT_EN
          err_q <= 1'b0;
`endif
        end else if (expire) begin
          state <= HOLD;
          vld_q <= 1'b1;
          sh_q <= '0;
`ifdef MRC_TIMEOUT_EN
          err_q <= 1'b1;
`endif
        end else begin
          rng_q <= lfsr[RND_W-1:0];
          lfsr <= lfsr_nx;
`ifdef MRC_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
        end
        default: if (bus.res_ready) begin
          state <= IDLE;
          vld_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_masked_run_ctrl.sv
// tb_masked_run_ctrl: directed checks of launch, randomness, capture, backpressure, reset abort and optional timeout
module tb_masked_run_ctrl;
  localparam int RW = 4;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] m;
  masked_run_ctrl_if #(.D(2), .RND_W(RW)) bus ();
  masked_run_ctrl #(.D(2), .RND_W(RW), .LAT_MAX(4), .SEED(SEED)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic fb;
    fb = s[0];
    return {fb, s[31:1]} ^ {10'b0, fb, 19'b0, fb, fb};
  endfunction
  task automatic launch;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    chk("launch_en", {31'b0, bus.dut_en}, 1);
    chk("launch_rng", {28'b0, bus.dut_rng}, {28'b0, m[RW-1:0]});
    chk("launch_ready", {31'b0, bus.start_ready}, 0);
    m = ref_step(m);
  endtask
  task automatic wait_cycle(input string tag);
    tick();
    chk({tag, "_en"}, {31'b0, bus.dut_en}, 0);
    chk({tag, "_rng"}, {28'b0, bus.dut_rng}, {28'b0, m[RW-1:0]});
    chk({tag, "_vld"}, {31'b0, bus.res_valid}, 0);
    m = ref_step(m);
  endtask
  task automatic finish_hold(input logic [1:0] sh, input logic err);
    tick();
    bus.dut_done = 1'b0;
    chk("hold_vld", {31'b0, bus.res_valid}, 1);
    chk("hold_sh", {30'b0, bus.res_shares}, {30'b0, sh});
    chk("hold_err", {31'b0, bus.res_err}, {31'b0, err});
    chk("hold_rng", {28'b0, bus.dut_rng}, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("idle_vld", {31'b0, bus.res_valid}, 0);
    chk("idle_rng", {28'b0, bus.dut_rng}, 0);
    chk("idle_ready", {31'b0, bus.start_ready}, 1);
  endtask
  task automatic run(input int lat, input logic [1:0] sh);
    launch();
    for (int k = 1; k <= lat; k++) begin
      wait_cycle("run_wait");
      if (k == lat) begin
        bus.dut_done = 1'b1;
        bus.dut_o = sh;
      end
    end
    finish_hold(sh, 1'b0);
  endtask
  initial begin
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.dut_done = 1'b0;
    bus.dut_o = 2'b00;
    m = SEED;
    repeat (3) tick();
    chk("rst_ready", {31'b0, bus.start_ready}, 0);
    rst = 1'b0;
    #1;
    chk("rst_en", {31'b0, bus.dut_en}, 0);
    chk("rst_rng", {28'b0, bus.dut_rng}, 0);
    chk("rst_vld", {31'b0, bus.res_valid}, 0);
    chk("rst_sh", {30'b0, bus.res_shares}, 0);
    chk("rst_err", {31'b0, bus.res_err}, 0);
    chk("rst_ready_rel", {31'b0, bus.start_ready}, 1);
    launch();
    wait_cycle("nom_w1");
    wait_cycle("nom_w2");
    bus.dut_done = 1'b1;
    bus.dut_o = 2'b10;
    tick();
    bus.dut_done = 1'b0;
    bus.dut_o = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) bus.res_ready = 1'b1;
      chk("bp_vld", {31'b0, bus.res_valid}, 1);
      chk("bp_sh", {30'b0, bus.res_shares}, 2);
      chk("bp_err", {31'b0, bus.res_err}, 0);
      chk("bp_ready", {31'b0, bus.start_ready}, 0);
      chk("bp_rng", {28'b0, bus.dut_rng}, 0);
      tick();
    end
    bus.res_ready = 1'b0;
    chk("bp_idle_vld", {31'b0, bus.res_valid}, 0);
    chk("bp_idle_ready", {31'b0, bus.start_ready}, 1);
    run(1, 2'b01);
    run(2, 2'b11);
    run(3, 2'b10);
    bus.dut_done = 1'b1;
    bus.dut_o = 2'b01;
    launch();
    wait_cycle("early_w1");
    bus.dut_o = 2'b11;
    tick();
    bus.dut_o = 2'b00;
    chk("held_vld", {31'b0, bus.res_valid}, 1);
    chk("held_sh", {30'b0, bus.res_shares}, 3);
    tick();
    chk("held_sh2", {30'b0, bus.res_shares}, 3);
    finish_hold(2'b11, 1'b0);
    launch();
    rst = 1'b1;
    tick();
    chk("abort_ready_rst", {31'b0, bus.start_ready}, 0);
    rst = 1'b0;
    bus.dut_done = 1'b1;
    bus.dut_o = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_vld", {31'b0, bus.res_valid}, 0);
      chk("abort_en", {31'b0, bus.dut_en}, 0);
      chk("abort_rng", {28'b0, bus.dut_rng}, 0);
      chk("abort_ready", {31'b0, bus.start_ready}, 1);
    end
    bus.dut_done = 1'b0;
    bus.dut_o = 2'b00;
    m = SEED;
    run(2, 2'b10);
`ifdef MRC_TIMEOUT_EN
    launch();
    for (int k = 1; k <= 4; k++) wait_cycle("to_wait");
    finish_hold(2'b00, 1'b1);
    launch();
    for (int k = 1; k <= 4; k++) begin
      wait_cycle("tie_wait");
      if (k == 4) begin
        bus.dut_done = 1'b1;
        bus.dut_o = 2'b01;
      end
    end
    finish_hold(2'b01, 1'b0);
`else
    run(9, 2'b01);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/masked_run_ctrl.md
# masked_run_ctrl

Sequencer for a single compiled masked gadget pipeline (d shares, one randomness port, `en`/`done` protocol). It accepts run requests over a valid/ready handshake and issues a one-cycle `en` launch pulse. While the run is in flight it supplies fresh per-cycle randomness from an internal LFSR, waits for `done`, and returns the captured output shares over a second valid/ready handshake. It sits between the system bus/test harness and the masked core, replacing hand-driven `en`/`rng` stimulus.

## Interface
- `D`, 2, number of shares per output bit (≥2).
- `RND_W`, 1, randomness bits consumed by the core per cycle (1..32).
- `LAT_MAX`, 16, WAIT-cycle budget before timeout (≥1; used only with `MRC_TIMEOUT_EN`).
- `SEED`, 32'hACE1_2468, LFSR reset value (must be nonzero).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  run request.
- `start_ready`  out  1  controller can accept a request.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_shares`  out  D  captured output shares, bit i = share i.
- `res_err`  out  1  result is a timeout, not a real output.
- `dut_en`  out  1  launch pulse to the core.
- `dut_rng`  out  RND_W  fresh randomness to the core.
- `dut_done`  in  1  core completion flag.
- `dut_o`  in  D  core output shares.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - `start_ready`=1.
  - On `start_valid`&`start_ready`, go to LAUNCH.
- LAUNCH:
  - Exactly one cycle with `dut_en`=1.
  - `dut_done` is ignored in this cycle.
  - Next state is always WAIT.
- WAIT:
  - `dut_en`=0.
  - On `dut_done`=1, register `dut_o` into `res_shares`, set `res_err`=0, go to HOLD.
- HOLD:
  - `res_valid`=1; `res_shares`/`res_err` stable.
  - On `res_ready`=1, go to IDLE.
- LFSR:
  - 32-bit Galois, taps for x^32+x^22+x^2+x+1.
  - Steps every cycle in LAUNCH and WAIT only; frozen in IDLE/HOLD.
  - `dut_rng` = `lfsr[RND_W-1:0]`, registered output, so a new value is presented every active cycle.
  - `dut_rng` is forced to 0 in IDLE/HOLD so stale masks never reach the core.
- `start_ready` is combinational on state: 1 only in IDLE and when `rst`=0.
- `start_valid` in non-IDLE states is ignored. Requests are not queued; the requester must hold `start_valid`.
- Share bits are never combined or unmasked inside this block. `res_shares` is a plain register copy, with no XOR across shares.

## Timing
- Reset: while `rst`=1 at a clock edge, the following load on that edge:
  - state=IDLE, `dut_en`=0, `dut_rng`=0, `res_valid`=0, `res_shares`=0, `res_err`=0, LFSR=`SEED`.
  - WAIT counter=0.
- Reset mid-run (any state) aborts immediately.
  - No result is produced.
  - Any `dut_done` arriving afterwards is ignored, since the state is IDLE.
- Latency:
  - Accept at edge t, `dut_en` high during cycle t+1.
  - Earliest `dut_done` is sampled at edge t+2; `res_valid` is high from cycle t+3.
- A core with latency L cycles after `en` gives `res_valid` L+1 cycles after the LAUNCH cycle.
- HOLD with `res_ready` already high: one cycle of `res_valid`, then IDLE.
- A new accept is possible in the following cycle (minimum 4 cycles per run).
- `dut_done` held high across multiple cycles: only the first WAIT sample is captured.

## Configuration
- `MRC_TIMEOUT_EN` defined:
  - A counter (width clog2(LAT_MAX+1)) clears on entering WAIT and increments each WAIT cycle without `dut_done`.
  - When it reaches `LAT_MAX`, go to HOLD with `res_err`=1 and `res_shares`=0.
  - `dut_done` in the same cycle as expiry wins: it is a normal result with `res_err`=0.
- `MRC_TIMEOUT_EN` undefined:
  - No counter; WAIT persists until `dut_done` or `rst`.
  - `res_err` is tied to 0.

## Test plan
- Reset: `rst`=1 for 3 cycles, then 0. Required: all outputs 0 except `start_ready`=1, and the first active `dut_rng` equals `SEED[RND_W-1:0]`.
- Nominal run with core latency 2 (model asserts `done` 2 cycles after `en`, `dut_o`=2'b10):
  - Required: `dut_en` high exactly one cycle.
  - `res_valid` rises 3 cycles after the LAUNCH cycle, with `res_shares`=2'b10 and `res_err`=0.
- Backpressure: `res_ready`=0 for 5 cycles in HOLD, then 1.
  - Required: `res_valid`/`res_shares` stable for all 6 cycles and `start_ready`=0 throughout.
  - `start_ready`=1 on the following cycle.
- Randomness: compare `dut_rng` against a reference LFSR over 3 back-to-back runs.
  - Required: values match every LAUNCH/WAIT cycle, `dut_rng`=0 in IDLE/HOLD, and no repeated sequence across runs.
- Reset mid-WAIT: assert `rst` 1 cycle after launch, then drive `dut_done`=1.
  - Required: no `res_valid` pulse, state IDLE, LFSR=`SEED`.
- With `MRC_TIMEOUT_EN`, `LAT_MAX`=4, core never asserts `done`:
  - Required: `res_valid`=1, `res_err`=1, `res_shares`=0 after 4 WAIT cycles.
  - Also: `done` coincident with expiry gives `res_err`=0.
